// File: rtl/pong_round_sequencer.sv
// Round and match sequencer for the Pong engine: game-tick generator, serve/play/point/over
// round FSM and per-player match score. All outputs are registered.
module pong_round_sequencer #(
  parameter int TICK_DIV    = 416667,
  parameter int SERVE_TICKS = 120,
  parameter int POINT_TICKS = 60,
  parameter int WIN_POINTS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  input  logic       two_player,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic       tick,
  output logic       engine_init,
  output logic       engine_run,
  output logic       serve_dir,
  output logic       mode_two,
  output logic [3:0] p1_points,
  output logic [3:0] p2_points,
  output logic [1:0] winner,
  output logic [2:0] state
);

  // A zero countdown would never expire, so it is treated as one tick.
  localparam int SERVE_LOAD = (SERVE_TICKS < 1) ? 1 : SERVE_TICKS;
  localparam int POINT_LOAD = (POINT_TICKS < 1) ? 1 : POINT_TICKS;
  localparam int MAX_LOAD   = (SERVE_LOAD > POINT_LOAD) ? SERVE_LOAD : POINT_LOAD;
  localparam int CW         = $clog2(MAX_LOAD + 1);
  localparam int TW         = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t          st;
  logic [TW-1:0]   tick_cnt;
  logic [CW-1:0]   countdown;
  logic            start_q;
  logic            start_rise;
  logic [3:0]      p1_next;
  logic [3:0]      p2_next;

  assign state      = st;
  assign start_rise = start & ~start_q;
  assign p1_next    = p1_points + 4'd1;
  assign p2_next    = p2_points + 4'd1;

  // tick is registered one count early so it is high while the counter sits at TICK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and the block order cannot create false ordering.
      tick     <= (tick_cnt == TW'(TICK_DIV - 2));
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IDLE;
      start_q     <= 1'b1;  // a button held through reset must not auto-start
      countdown   <= '0;
      engine_init <= 1'b0;
      engine_run  <= 1'b0;
      serve_dir   <= 1'b0;
      mode_two    <= 1'b0;
      p1_points   <= 4'd0;
      p2_points   <= 4'd0;
      winner      <= 2'b00;
    end else begin
      start_q     <= start;
      engine_init <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start_rise) begin
            mode_two    <= two_player;
            p1_points   <= 4'd0;
            p2_points   <= 4'd0;
            serve_dir   <= 1'b0;
            engine_init <= 1'b1;
            countdown   <= CW'(SERVE_LOAD);
            st          <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (tick) begin
            if (countdown == CW'(1)) begin
              st         <= S_PLAY;
              engine_run <= 1'b1;
            end else begin
              countdown <= countdown - CW'(1);
            end
          end
        end
        S_PLAY: begin
          if (!mode_two) begin
            if (miss_p1) begin
              winner     <= 2'b11;
              engine_run <= 1'b0;
              st         <= S_OVER;
            end
          end else if (miss_p1 && miss_p2) begin
            engine_run <= 1'b0;
            countdown  <= CW'(POINT_LOAD);
            st         <= S_POINT;
          end else if (miss_p1) begin
            p2_points  <= p2_next;
            serve_dir  <= 1'b0;
            engine_run <= 1'b0;
            if (p2_next == 4'(WIN_POINTS)) begin
              winner <= 2'b10;
              st     <= S_OVER;
            end else begin
              countdown <= CW'(POINT_LOAD);
              st        <= S_POINT;
            end
          end else if (miss_p2) begin
            p1_points  <= p1_next;
            serve_dir  <= 1'b1;
            engine_run <= 1'b0;
            if (p1_next == 4'(WIN_POINTS)) begin
              winner <= 2'b01;
              st     <= S_OVER;
            end else begin
              countdown <= CW'(POINT_LOAD);
              st        <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (tick) begin
            if (countdown == CW'(1)) begin
              engine_init <= 1'b1;
              countdown   <= CW'(SERVE_LOAD);
              st          <= S_SERVE;
            end else begin
              countdown <= countdown - CW'(1);
            end
          end
        end
        S_OVER: begin
          // Scores stay on display after acknowledge; only the next start clears them.
          if (ack) begin
            winner <= 2'b00;
            st     <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
